// File: rtl/multi_phase_sequencer.sv
// One-hot phase sequencer: rotates an NPHASE-bit phase forward/reverse, stepping
// from an internal rate prescaler or a ready/request handshake, with position tracking.
module multi_phase_sequencer #(
  parameter int NPHASE = 5,
  parameter int DIV_W  = 16,
  parameter int POS_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic              dir,
  input  logic [DIV_W-1:0]  div,
  input  logic              step_req,
  output logic              step_rdy,
  input  logic              load,
  input  logic [NPHASE-1:0] load_phase,
  output logic [NPHASE-1:0] phase,
  output logic [POS_W-1:0]  position,
  output logic              step_pulse,
  output logic              fault
);

  localparam logic [NPHASE-1:0] PH_INIT = NPHASE'(1);

  logic [NPHASE-1:0] r_phase, w_phase_nxt;
  logic [POS_W-1:0]  r_pos, w_pos_nxt;
  logic [DIV_W-1:0]  r_count, w_count_nxt;
  logic              r_pulse, w_pulse_nxt;
  logic              r_fault, w_fault_nxt;
  logic              w_at_div, w_phase_ok, w_load_ok, w_step;

  function automatic logic is_onehot(input logic [NPHASE-1:0] v);
    return (v != '0) && ((v & (v - NPHASE'(1))) == '0);
  endfunction

  always_comb begin
    w_at_div   = (r_count >= div);
    w_phase_ok = is_onehot(r_phase);
    w_load_ok  = is_onehot(load_phase);
    step_rdy   = enable & mode & w_at_div;
    // A corrupted phase or a load suppresses the step on that edge.
    w_step     = enable & ~load & w_phase_ok & (mode ? (step_req & w_at_div) : w_at_div);
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_pos_nxt   = r_pos;
    w_count_nxt = r_count;
    w_pulse_nxt = 1'b0;
    w_fault_nxt = r_fault;
    if (load) begin
      if (w_load_ok) begin
        w_phase_nxt = load_phase;
      end else begin
        w_phase_nxt = PH_INIT;
        w_fault_nxt = 1'b1;
      end
    end else begin
      if (!enable) begin
        w_count_nxt = '0;
      end else if (w_step) begin
        w_count_nxt = '0;
      end else if (r_count < div) begin
        w_count_nxt = r_count + DIV_W'(1);
      end

      if (!w_phase_ok) begin
        w_phase_nxt = PH_INIT;
        w_fault_nxt = 1'b1;
      end else if (w_step) begin
        w_pulse_nxt = 1'b1;
        if (dir) begin
          w_phase_nxt = {r_phase[0], r_phase[NPHASE-1:1]};
          w_pos_nxt   = r_pos - POS_W'(1);
        end else begin
          w_phase_nxt = {r_phase[NPHASE-2:0], r_phase[NPHASE-1]};
          w_pos_nxt   = r_pos + POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= PH_INIT;
      r_pos   <= '0;
      r_count <= '0;
      r_pulse <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_pos   <= w_pos_nxt;
      r_count <= w_count_nxt;
      r_pulse <= w_pulse_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  assign phase      = r_phase;
  assign position   = r_pos;
  assign step_pulse = r_pulse;
  assign fault      = r_fault;

endmodule

// File: tb/tb_multi_phase_sequencer.sv
// Directed vector bench for multi_phase_sequencer (NPHASE=5, 16-bit div/position).
module tb_multi_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, mode, dir, step_req, load;
  logic [15:0] div;
  logic [4:0]  load_phase;
  logic        step_rdy, step_pulse, fault;
  logic [4:0]  phase;
  logic [15:0] position;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multi_phase_sequencer #(.NPHASE(5), .DIV_W(16), .POS_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .dir(dir), .div(div),
    .step_req(step_req), .step_rdy(step_rdy), .load(load), .load_phase(load_phase),
    .phase(phase), .position(position), .step_pulse(step_pulse), .fault(fault)
  );

  typedef struct {
    logic        rst, en, mode, dir;
    logic [15:0] div;
    logic        req, ld;
    logic [4:0]  lp;
    logic [4:0]  e_phase;
    logic [15:0] e_pos;
    logic        e_pulse, e_fault, e_rdy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic en, input logic md, input logic dr,
                     input logic [15:0] dv, input logic rq, input logic ld, input logic [4:0] lp,
                     input logic [4:0] eph, input logic [15:0] epos,
                     input logic epl, input logic ef, input logic erdy);
    vec_t v;
    v.rst = r; v.en = en; v.mode = md; v.dir = dr; v.div = dv; v.req = rq;
    v.ld = ld; v.lp = lp; v.e_phase = eph; v.e_pos = epos;
    v.e_pulse = epl; v.e_fault = ef; v.e_rdy = erdy;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [4:0] eph, input logic [15:0] epos,
                         input logic epl, input logic ef, input logic erdy);
    chk({tag, ".phase"},    32'(phase),      32'(eph));
    chk({tag, ".position"}, 32'(position),   32'(epos));
    chk({tag, ".pulse"},    32'(step_pulse), 32'(epl));
    chk({tag, ".fault"},    32'(fault),      32'(ef));
    chk({tag, ".rdy"},      32'(step_rdy),   32'(erdy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic en, input logic md, input logic dr,
                       input logic [15:0] dv, input logic rq, input logic ld, input logic [4:0] lp);
    rst = r; enable = en; mode = md; dir = dr; div = dv;
    step_req = rq; load = ld; load_phase = lp;
  endtask

  initial begin
    drive(1, 0, 0, 0, 16'd0, 0, 0, 5'b0);
    #2;
    chk_all("reset_state", 5'b00001, 16'd0, 0, 0, 0);

    // Forward free-run, div=0
    //   rst en md dr div req ld lp        phase     pos      pl f  rdy
    add(1, 0, 0, 0, 16'd0, 0, 0, 5'b0, 5'b00001, 16'd0, 0, 0, 0);
    add(0, 1, 0, 0, 16'd0, 0, 0, 5'b0, 5'b00010, 16'd1, 1, 0, 0);
    add(0, 1, 0, 0, 16'd0, 0, 0, 5'b0, 5'b00100, 16'd2, 1, 0, 0);
    add(0, 1, 0, 0, 16'd0, 0, 0, 5'b0, 5'b01000, 16'd3, 1, 0, 0);
    add(0, 1, 0, 0, 16'd0, 0, 0, 5'b0, 5'b10000, 16'd4, 1, 0, 0);
    add(0, 1, 0, 0, 16'd0, 0, 0, 5'b0, 5'b00001, 16'd5, 1, 0, 0);
    // Reverse with position wrap, then one forward step
    add(1, 0, 0, 0, 16'd0, 0, 0, 5'b0, 5'b00001, 16'd0, 0, 0, 0);
    add(0, 1, 0, 1, 16'd0, 0, 0, 5'b0, 5'b10000, 16'hFFFF, 1, 0, 0);
    add(0, 1, 0, 1, 16'd0, 0, 0, 5'b0, 5'b01000, 16'hFFFE, 1, 0, 0);
    add(0, 1, 0, 0, 16'd0, 0, 0, 5'b0, 5'b10000, 16'hFFFF, 1, 0, 0);
    // Rate div=3: one step per 4 edges, enable dropped for 2 cycles
    add(1, 0, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00001, 16'd0, 0, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00001, 16'd0, 0, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00001, 16'd0, 0, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00001, 16'd0, 0, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00010, 16'd1, 1, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00010, 16'd1, 0, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00010, 16'd1, 0, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00010, 16'd1, 0, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00100, 16'd2, 1, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00100, 16'd2, 0, 0, 0);
    add(0, 0, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00100, 16'd2, 0, 0, 0);
    add(0, 0, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00100, 16'd2, 0, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00100, 16'd2, 0, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00100, 16'd2, 0, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b00100, 16'd2, 0, 0, 0);
    add(0, 1, 0, 0, 16'd3, 0, 0, 5'b0, 5'b01000, 16'd3, 1, 0, 0);
    // Handshake div=2, req held; then a dropped request while not ready
    add(1, 0, 1, 0, 16'd2, 0, 0, 5'b0, 5'b00001, 16'd0, 0, 0, 0);
    add(0, 1, 1, 0, 16'd2, 1, 0, 5'b0, 5'b00001, 16'd0, 0, 0, 0);
    add(0, 1, 1, 0, 16'd2, 1, 0, 5'b0, 5'b00001, 16'd0, 0, 0, 1);
    add(0, 1, 1, 0, 16'd2, 1, 0, 5'b0, 5'b00010, 16'd1, 1, 0, 0);
    add(0, 1, 1, 0, 16'd2, 1, 0, 5'b0, 5'b00010, 16'd1, 0, 0, 0);
    add(0, 1, 1, 0, 16'd2, 1, 0, 5'b0, 5'b00010, 16'd1, 0, 0, 1);
    add(0, 1, 1, 0, 16'd2, 1, 0, 5'b0, 5'b00100, 16'd2, 1, 0, 0);
    add(0, 1, 1, 0, 16'd2, 1, 0, 5'b0, 5'b00100, 16'd2, 0, 0, 0);
    add(0, 1, 1, 0, 16'd2, 0, 0, 5'b0, 5'b00100, 16'd2, 0, 0, 1);
    add(0, 1, 1, 0, 16'd2, 0, 0, 5'b0, 5'b00100, 16'd2, 0, 0, 1);
    add(0, 1, 1, 0, 16'd2, 1, 0, 5'b0, 5'b01000, 16'd3, 1, 0, 0);
    // Load and fault handling on would-be step edges
    add(1, 0, 0, 0, 16'd0, 0, 0, 5'b0, 5'b00001, 16'd0, 0, 0, 0);
    add(0, 1, 0, 0, 16'd0, 0, 1, 5'b00100, 5'b00100, 16'd0, 0, 0, 0);
    add(0, 1, 0, 0, 16'd0, 0, 0, 5'b00000, 5'b01000, 16'd1, 1, 0, 0);
    add(0, 1, 0, 0, 16'd0, 0, 1, 5'b00000, 5'b00001, 16'd1, 0, 1, 0);
    add(0, 1, 0, 0, 16'd0, 0, 1, 5'b10000, 5'b10000, 16'd1, 0, 1, 0);
    add(0, 1, 0, 0, 16'd0, 0, 0, 5'b00000, 5'b00001, 16'd2, 1, 1, 0);
    add(0, 1, 0, 0, 16'd0, 0, 1, 5'b00110, 5'b00001, 16'd2, 0, 1, 0);
    add(0, 0, 0, 0, 16'd0, 0, 1, 5'b01000, 5'b01000, 16'd2, 0, 1, 0);
    add(1, 0, 0, 0, 16'd0, 0, 0, 5'b00000, 5'b00001, 16'd0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].en, vq[i].mode, vq[i].dir, vq[i].div,
            vq[i].req, vq[i].ld, vq[i].lp);
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].e_phase, vq[i].e_pos,
              vq[i].e_pulse, vq[i].e_fault, vq[i].e_rdy);
    end

    // Asynchronous reset between edges, with fault and position non-zero
    drive(0, 1, 0, 0, 16'd0, 0, 1, 5'b00000);
    tick();
    chk("arst_prefault", 32'(fault), 32'd1);
    load = 1'b0;
    tick(); tick(); tick();
    chk("arst_pre_pos",   32'(position), 32'd3);
    chk("arst_pre_phase", 32'(phase),    32'b01000);
    #3 rst = 1'b1;
    #1;
    chk("arst_phase", 32'(phase),      32'b00001);
    chk("arst_pos",   32'(position),   32'd0);
    chk("arst_pulse", 32'(step_pulse), 32'd0);
    chk("arst_fault", 32'(fault),      32'd0);
    #2 rst = 1'b0;
    tick();
    chk("arst_first_step_phase", 32'(phase),      32'b00010);
    chk("arst_first_step_pulse", 32'(step_pulse), 32'd1);

    // Lowering div below the running count steps on the next edge
    drive(1, 0, 0, 0, 16'd7, 0, 0, 5'b0);
    tick();
    rst = 1'b0; enable = 1'b1;
    tick(); tick(); tick();
    chk("divdrop_pre_pulse", 32'(step_pulse), 32'd0);
    chk("divdrop_pre_phase", 32'(phase),      32'b00001);
    div = 16'd2;
    tick();
    chk("divdrop_pulse", 32'(step_pulse), 32'd1);
    chk("divdrop_phase", 32'(phase),      32'b00010);
    chk("divdrop_pos",   32'(position),   32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_phase_sequencer.md
# multi_phase_sequencer

Parametrised successor to the fixed 5-phase counter. It owns a one-hot phase register of NPHASE bits and rotates it forward or reverse. Steps come either from an internal rate prescaler (free-run) or from a ready/request handshake. It also keeps a signed step-position count and recovers from illegal phase codes. It sits between the motion/sequence controller and the phase drivers.

## Interface
- NPHASE, 5, number of phases (≥2); width of phase vectors
- DIV_W, 16, width of step-period divider
- POS_W, 16, width of position counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  1 = sequencing allowed; 0 = hold phase, prescaler cleared
- mode  in  1  0 = free-run at divider rate; 1 = step on request
- dir  in  1  0 = forward (bit i→i+1, MSB→bit0); 1 = reverse
- div  in  DIV_W  step period minus 1, in clk cycles
- step_req  in  1  step request (mode 1)
- step_rdy  out  1  sequencer can accept step_req this cycle
- load  in  1  load phase from load_phase (priority over stepping)
- load_phase  in  NPHASE  phase value to load
- phase  out  NPHASE  current one-hot phase
- position  out  POS_W  two's-complement step count
- step_pulse  out  1  high for the one cycle in which a new stepped phase is presented
- fault  out  1  sticky illegal-phase flag

## Operation
- Reset values: phase = 1 (bit0), position = 0, prescaler count = 0, step_pulse = 0, fault = 0.
- Step condition, evaluated per edge:
  - mode 0: enable & (count ≥ div).
  - mode 1: enable & step_req & step_rdy.
- step_rdy = enable & mode & (count ≥ div). It is combinational from registered count.
- Prescaler behaviour:
  - enable=0: count forced to 0.
  - On a step edge: count ← 0.
  - Otherwise: count increments, saturating at div. In mode 1 it waits at div.
- Comparison is ≥, so lowering div mid-count causes a step at the next qualifying edge.
- div = 0 steps every cycle (mode 0), or accepts a request every cycle (mode 1).
- On a step:
  - phase rotates per dir sampled on that edge.
  - position += 1 (forward) or −= 1 (reverse), wrapping modulo 2^POS_W.
- step_req while step_rdy=0 is dropped, not queued.
- load=1 (regardless of enable/mode):
  - If load_phase is exactly one-hot: phase ← load_phase.
  - Otherwise (including all-zero): phase ← bit0 and fault ← 1.
  - No step occurs that edge; position and count are unchanged.
  - step_pulse = 0 next cycle.
- Integrity check: if the phase register is ever not one-hot, the next edge forces bit0 and sets fault. This check has priority over stepping; load still wins.
- enable=0: phase and position hold, step_pulse = 0, step_rdy = 0.
- fault clears only on rst.

## Timing
- Step latency:
  - The new phase and position are visible the cycle after the step edge.
  - step_pulse is registered and high in that same cycle only.
- Free-run step period is div+1 cycles. The first step comes div+1 edges after enable rises, with count starting at 0.
- Request mode handshake: transfer on an edge with step_req & step_rdy.
  - step_rdy drops the next cycle.
  - step_rdy returns div cycles later.
  - step_req held high gives one step per div+1 cycles.
- dir and mode changes take effect on the next qualifying edge. A mode change does not reset count.
- rst mid-operation clears all state immediately, independent of clk. The first step after release follows the normal prescaler rules.

## Test plan
- Forward free-run: NPHASE=5, mode=0, div=0, dir=0, enable=1 after reset → phase 00001→00010→00100→01000→10000→00001 on consecutive cycles; position 1,2,3,4,5; step_pulse high continuously.
- Reverse with wrap: same setup from reset, dir=1, 2 steps → phase 10000, 01000; position 0xFFFF, 0xFFFE; then dir=0 for 1 step → phase 10000, position 0xFFFF.
- Rate: mode=0, div=3 → step_pulse high exactly 1 of every 4 cycles. Drop enable for 2 cycles → phase holds, and the next step comes 4 cycles after re-enable.
- Handshake: mode=1, div=2, step_req held → steps every 3 cycles; step_rdy low 2 cycles after each step. A single step_req pulse during step_rdy=0 → no step, position unchanged.
- Load/fault:
  - load_phase=00100 with load=1 on a would-be step edge → phase 00100, position unchanged, step_pulse 0, fault 0.
  - load_phase=00000 → phase 00001, fault 1. fault stays 1 through further legal loads until rst.
  - load_phase=00110 → phase 00001, fault 1.
- Async reset: assert rst mid-period between clk edges → phase 00001, position 0, step_pulse 0, fault 0 immediately.
